i2c_slave_byte_rx: RTL



---
 rtl/i2c_slave_byte_rx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_byte_rx.sv
// Write-only I2C slave receiver: oversamples SCL/SDA, matches a 7-bit address,
// ACKs every byte and emits each data byte with a one-cycle done strobe.
module i2c_slave_byte_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] slave_data_out,
  output logic       done,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    WAIT_STOP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_scl_s1, r_scl_s2, r_scl_d;
  logic        r_sda_s1, r_sda_s2, r_sda_d;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_sda_oe, w_sda_oe_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic [7:0]  r_data, w_data_nxt;

  logic        w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_match;
  logic [7:0]  w_shift_in;
  logic [3:0]  w_cnt_inc;

  // Synchronisers reset to 1 so a released reset on an idle bus sees no edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_scl_rise   = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall   = ~r_scl_s2 & r_scl_d;
  assign w_start      = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
  assign w_stop       = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
  assign w_shift_in   = {r_shift[6:0], r_sda_s2};
  assign w_cnt_inc    = (r_cnt == 4'd8) ? 4'd8 : r_cnt + 4'd1;
  assign w_addr_match = (r_shift[7:1] == SLAVE_ADDR) && !r_shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Bus conditions are tested before bit sampling so START/STOP always win
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_cnt_nxt    = r_cnt;
    w_sda_oe_nxt = r_sda_oe;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_data_nxt   = r_data;

    if (w_start) begin
      w_state_nxt  = ADDR;
      w_cnt_nxt    = 4'd0;
      w_shift_nxt  = 8'h00;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = IDLE;
      w_cnt_nxt    = 4'd0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = w_cnt_inc;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            if (w_addr_match) begin
              w_state_nxt  = ADDR_ACK;
              w_sda_oe_nxt = 1'b1;
              w_busy_nxt   = 1'b1;
            end else begin
              w_state_nxt  = WAIT_STOP;
              w_sda_oe_nxt = 1'b0;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          w_sda_oe_nxt = 1'b1;
          if (w_scl_fall) begin
            w_state_nxt  = DATA;
            w_cnt_nxt    = 4'd0;
            w_sda_oe_nxt = 1'b0;
          end
        end
        DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = w_cnt_inc;
            if (r_cnt == 4'd7) begin
              w_data_nxt = w_shift_in;
              w_done_nxt = 1'b1;
            end
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_state_nxt  = DATA_ACK;
            w_sda_oe_nxt = 1'b1;
          end
        end
        WAIT_STOP: ;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= 8'h00;
      r_cnt    <= 4'd0;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_data   <= 8'h00;
    end else begin
      r_shift  <= w_shift_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sda_oe <= w_sda_oe_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_data   <= w_data_nxt;
    end
  end

  assign sda_oe         = r_sda_oe;
  assign busy           = r_busy;
  assign done           = r_done;
  assign slave_data_out = r_data;

endmodule
